// File: rtl/lc3_execute.sv
// LC-3 execute stage: operand forwarding, ALU, address generation and the
// EX/MEM pipeline register.
module lc3_execute (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_execute,
  input  logic [15:0] IR,
  input  logic [15:0] npc_in,
  input  logic [5:0]  E_control,
  input  logic        Mem_Control_in,
  input  logic [1:0]  W_Control_in,
  input  logic        bypass_alu_1,
  input  logic        bypass_alu_2,
  input  logic        bypass_mem_1,
  input  logic        bypass_mem_2,
  input  logic [15:0] VSR1,
  input  logic [15:0] VSR2,
  input  logic [15:0] Mem_bypass_val,
  output logic [15:0] aluout,
  output logic [15:0] pcout,
  output logic [1:0]  W_Control_out,
  output logic        Mem_Control_out,
  output logic [15:0] M_Data,
  output logic [2:0]  dr,
  output logic [15:0] IR_Exec,
  output logic [2:0]  NZP,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2
);

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000,
    OP_ADD = 4'b0001,
    OP_LD  = 4'b0010,
    OP_ST  = 4'b0011,
    OP_AND = 4'b0101,
    OP_LDR = 4'b0110,
    OP_STR = 4'b0111,
    OP_NOT = 4'b1001,
    OP_LDI = 4'b1010,
    OP_STI = 4'b1011,
    OP_JMP = 4'b1100,
    OP_LEA = 4'b1110
  } opcode_e;

  logic [15:0] aluout_q, aluout_d;
  logic [15:0] pcout_q, pcout_d;
  logic [1:0]  wctl_q, wctl_d;
  logic        memctl_q, memctl_d;
  logic [15:0] mdata_q, mdata_d;
  logic [2:0]  dr_q, dr_d;
  logic [15:0] irexec_q, irexec_d;
  logic [2:0]  nzp_q, nzp_d;

  logic [3:0]  opcode;
  logic [1:0]  aluControl;
  logic [1:0]  pcSelect1;
  logic        pcSelect2;
  logic        op2Select;
  logic [15:0] val1, val2, aluOp2, aluResult;
  logic [15:0] addrBase, addrOffset, address;
  logic        isStore;

  assign opcode     = IR[15:12];
  assign aluControl = E_control[5:4];
  assign pcSelect1  = E_control[3:2];
  assign pcSelect2  = E_control[1];
  assign op2Select  = E_control[0];

  assign isStore = (opcode == OP_ST) || (opcode == OP_STR) || (opcode == OP_STI);

  // Source indices come straight from the incoming IR so decode can read the
  // register file in the same cycle, independent of the capture enable.
  assign sr1 = IR[8:6];
  assign sr2 = isStore ? IR[11:9] : IR[2:0];

  // Forwarding: the registered ALU result has priority over the memory stage.
  assign val1 = bypass_alu_1 ? aluout_q : (bypass_mem_1 ? Mem_bypass_val : VSR1);
  assign val2 = bypass_alu_2 ? aluout_q : (bypass_mem_2 ? Mem_bypass_val : VSR2);

  assign aluOp2 = op2Select ? val2 : {{11{IR[4]}}, IR[4:0]};

  always_comb begin
    aluResult = 16'h0000;
    case (aluControl)
      2'b00:   aluResult = val1 + aluOp2;
      2'b01:   aluResult = val1 & aluOp2;
      2'b10:   aluResult = ~val1;
      default: aluResult = 16'h0000;
    endcase
  end

  always_comb begin
    addrOffset = 16'h0000;
    case (pcSelect1)
      2'b00:   addrOffset = {{5{IR[10]}}, IR[10:0]};
      2'b01:   addrOffset = {{7{IR[8]}}, IR[8:0]};
      2'b10:   addrOffset = {{10{IR[5]}}, IR[5:0]};
      default: addrOffset = 16'h0000;
    endcase
  end

  assign addrBase = pcSelect2 ? npc_in : val1;
  assign address  = addrBase + addrOffset;

  always_comb begin
    aluout_d = aluout_q;
    pcout_d  = address;
    wctl_d   = W_Control_in;
    memctl_d = Mem_Control_in;
    mdata_d  = mdata_q;
    dr_d     = 3'b000;
    irexec_d = IR;
    nzp_d    = 3'b000;
    case (opcode)
      OP_ADD, OP_AND, OP_NOT: begin
        aluout_d = aluResult;
        dr_d     = IR[11:9];
      end
      OP_LEA: begin
        aluout_d = address;
        dr_d     = IR[11:9];
      end
      OP_LD, OP_LDR, OP_LDI: dr_d = IR[11:9];
      OP_ST, OP_STR, OP_STI: mdata_d = val2;
      OP_BR:  nzp_d = IR[11:9];
      OP_JMP: nzp_d = 3'b111;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aluout_q <= 16'h0000;
      pcout_q  <= 16'h0000;
      wctl_q   <= 2'b00;
      memctl_q <= 1'b0;
      mdata_q  <= 16'h0000;
      dr_q     <= 3'b000;
      irexec_q <= 16'h0000;
      nzp_q    <= 3'b000;
    end else if (enable_execute) begin
      aluout_q <= aluout_d;
      pcout_q  <= pcout_d;
      wctl_q   <= wctl_d;
      memctl_q <= memctl_d;
      mdata_q  <= mdata_d;
      dr_q     <= dr_d;
      irexec_q <= irexec_d;
      nzp_q    <= nzp_d;
    end
  end

  assign aluout          = aluout_q;
  assign pcout           = pcout_q;
  assign W_Control_out   = wctl_q;
  assign Mem_Control_out = memctl_q;
  assign M_Data          = mdata_q;
  assign dr              = dr_q;
  assign IR_Exec         = irexec_q;
  assign NZP             = nzp_q;

endmodule

// File: tb/tb_lc3_execute.sv
// Directed-vector bench for lc3_execute: a table of instructions with
// hand-computed results, then enable-hold and asynchronous-reset sequences.
module tb_lc3_execute;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_execute;
  logic [15:0] IR, npc_in, VSR1, VSR2, Mem_bypass_val;
  logic [5:0]  E_control;
  logic        Mem_Control_in;
  logic [1:0]  W_Control_in;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [15:0] aluout, pcout, M_Data, IR_Exec;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;
  logic [2:0]  dr, NZP, sr1, sr2;

  int errors = 0;
  int checks = 0;

  lc3_execute dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute),
    .IR(IR), .npc_in(npc_in), .E_control(E_control),
    .Mem_Control_in(Mem_Control_in), .W_Control_in(W_Control_in),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
    .VSR1(VSR1), .VSR2(VSR2), .Mem_bypass_val(Mem_bypass_val),
    .aluout(aluout), .pcout(pcout), .W_Control_out(W_Control_out),
    .Mem_Control_out(Mem_Control_out), .M_Data(M_Data), .dr(dr),
    .IR_Exec(IR_Exec), .NZP(NZP), .sr1(sr1), .sr2(sr2)
  );

  always #5 clock = ~clock;

  // bypass field is {alu_1, alu_2, mem_1, mem_2}
  typedef struct {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [5:0]  ectl;
    logic [3:0]  byp;
    logic [15:0] vsr1;
    logic [15:0] vsr2;
    logic [15:0] mbv;
    logic [15:0] expAlu;
    logic [15:0] expPc;
    logic [15:0] expMd;
    logic [2:0]  expDr;
    logic [2:0]  expNzp;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  function automatic logic [2:0] expSr2(input logic [15:0] ir);
    logic [3:0] op;
    op = ir[15:12];
    if (op == 4'b0011 || op == 4'b0111 || op == 4'b1011) return ir[11:9];
    return ir[2:0];
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input logic [1:0] wctl, input logic memctl);
    IR             = v.ir;
    npc_in         = v.npc;
    E_control      = v.ectl;
    {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} = v.byp;
    VSR1           = v.vsr1;
    VSR2           = v.vsr2;
    Mem_bypass_val = v.mbv;
    W_Control_in   = wctl;
    Mem_Control_in = memctl;
    enable_execute = 1'b1;
  endtask

  task automatic checkRegs(input string tag, input logic [15:0] eAlu, input logic [15:0] ePc,
                           input logic [15:0] eMd, input logic [2:0] eDr, input logic [2:0] eNzp,
                           input logic [15:0] eIr, input logic [1:0] eW, input logic eM);
    checkOutput({tag, ".aluout"}, aluout, eAlu);
    checkOutput({tag, ".pcout"}, pcout, ePc);
    checkOutput({tag, ".M_Data"}, M_Data, eMd);
    checkOutput({tag, ".dr"}, {13'd0, dr}, {13'd0, eDr});
    checkOutput({tag, ".NZP"}, {13'd0, NZP}, {13'd0, eNzp});
    checkOutput({tag, ".IR_Exec"}, IR_Exec, eIr);
    checkOutput({tag, ".W_Control_out"}, {14'd0, W_Control_out}, {14'd0, eW});
    checkOutput({tag, ".Mem_Control_out"}, {15'd0, Mem_Control_out}, {15'd0, eM});
  endtask

  task automatic checkSr(input string tag, input logic [15:0] ir);
    checkOutput({tag, ".sr1"}, {13'd0, sr1}, {13'd0, ir[8:6]});
    checkOutput({tag, ".sr2"}, {13'd0, sr2}, {13'd0, expSr2(ir)});
  endtask

  initial begin
    //                ir       npc      ectl       byp      vsr1     vsr2     mbv      alu      pc       md       dr    nzp
    vecs[0]  = '{16'h127F, 16'h3000, 6'b000000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h027F, 16'h0000, 3'd1, 3'b000};
    vecs[1]  = '{16'h1642, 16'h3000, 6'b000001, 4'b0000, 16'h0005, 16'h0003, 16'h0000, 16'h0008, 16'hFE47, 16'h0000, 3'd3, 3'b000};
    vecs[2]  = '{16'h1642, 16'h3000, 6'b000001, 4'b1010, 16'h5555, 16'h0003, 16'h1234, 16'h000B, 16'hFE4A, 16'h0000, 3'd3, 3'b000};
    vecs[3]  = '{16'h5642, 16'h3000, 6'b010001, 4'b0010, 16'hFFFF, 16'h00FF, 16'h0F0F, 16'h000F, 16'h0D51, 16'h0000, 3'd3, 3'b000};
    vecs[4]  = '{16'h9A7F, 16'h3000, 6'b100000, 4'b0000, 16'h1234, 16'h0000, 16'h0000, 16'hEDCB, 16'h14B3, 16'h0000, 3'd5, 3'b000};
    vecs[5]  = '{16'h0404, 16'h3001, 6'b000110, 4'b0000, 16'h7777, 16'h0000, 16'h0000, 16'hEDCB, 16'h3005, 16'h0000, 3'd0, 3'b010};
    vecs[6]  = '{16'hC1C0, 16'h3000, 6'b001100, 4'b0000, 16'h4000, 16'h0000, 16'h0000, 16'hEDCB, 16'h4000, 16'h0000, 3'd0, 3'b111};
    vecs[7]  = '{16'h3A05, 16'h3010, 6'b000110, 4'b0001, 16'h0000, 16'h1111, 16'hBEEF, 16'hEDCB, 16'h3015, 16'hBEEF, 3'd0, 3'b000};
    vecs[8]  = '{16'h7E7F, 16'h3000, 6'b001000, 4'b0100, 16'h2000, 16'h1111, 16'h0000, 16'hEDCB, 16'h1FFF, 16'hEDCB, 3'd0, 3'b000};
    vecs[9]  = '{16'hA3FF, 16'h3000, 6'b000110, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'hEDCB, 16'h2FFF, 16'hEDCB, 3'd1, 3'b000};
    vecs[10] = '{16'hE7FE, 16'h3000, 6'b000110, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h2FFE, 16'h2FFE, 16'hEDCB, 3'd3, 3'b000};
    vecs[11] = '{16'h1E00, 16'h3000, 6'b110001, 4'b0000, 16'h0100, 16'h0055, 16'h0000, 16'h0000, 16'hFF00, 16'hEDCB, 3'd7, 3'b000};
    vecs[12] = '{16'h2C03, 16'h3000, 6'b000110, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3003, 16'hEDCB, 3'd6, 3'b000};

    // Reset held with enable high and live inputs: nothing may be captured.
    reset = 1'b1;
    applyStimulus(vecs[1], 2'b11, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    checkRegs("reset", 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 16'h0, 2'b00, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], i[1:0], i[0]);
      #1;
      checkSr($sformatf("v%0d", i), vecs[i].ir);
      @(posedge clock);
      #1;
      checkRegs($sformatf("v%0d", i), vecs[i].expAlu, vecs[i].expPc, vecs[i].expMd,
                vecs[i].expDr, vecs[i].expNzp, vecs[i].ir, i[1:0], i[0]);
    end

    // Enable low for three cycles while every input moves around.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(vecs[c * 3 + 1], 2'b11, 1'b1);
      IR = (c == 0) ? 16'h3A05 : (c == 1) ? 16'h1642 : 16'h7E7F;
      VSR1 = 16'hA5A5 + 16'(c);
      enable_execute = 1'b0;
      #1;
      checkSr($sformatf("hold%0d", c), IR);
      @(posedge clock);
      #1;
      checkRegs($sformatf("hold%0d", c), 16'h0000, 16'h3003, 16'hEDCB, 3'd6, 3'd0,
                16'h2C03, 2'b00, 1'b0);
    end

    // Asynchronous reset arriving between edges after a completed ADD.
    applyStimulus(vecs[1], 2'b10, 1'b1);
    @(posedge clock);
    #1;
    checkOutput("preReset.aluout", aluout, 16'h0008);
    #1;
    reset = 1'b1;
    #1;
    checkRegs("asyncReset", 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 16'h0, 2'b00, 1'b0);
    @(posedge clock);
    #1;
    checkRegs("resetHeld", 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 16'h0, 2'b00, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkRegs("postReset", 16'h0008, 16'hFE47, 16'h0000, 3'd3, 3'd0, 16'h1642, 2'b10, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_execute.md
LC3_EXECUTE -- requirements
Module: lc3_execute

Interface
REQ-001 Parameters: none; all widths fixed by the LC-3 ISA.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 enable_execute  in  1  capture enable; registered outputs update only when 1.
REQ-005 IR  in  16  instruction from decode.
REQ-006 npc_in  in  16  PC+1 of the instruction.
REQ-007 E_control  in  6  {alu_control[5:4], pcselect1[3:2], pcselect2[1], op2select[0]}.
REQ-008 Mem_Control_in  in  1  memory control, passed through.
REQ-009 W_Control_in  in  2  writeback control, passed through.
REQ-010 bypass_alu_1 / bypass_alu_2  in  1 each  select current aluout for operand 1 / 2.
REQ-011 bypass_mem_1 / bypass_mem_2  in  1 each  select Mem_bypass_val for operand 1 / 2.
REQ-012 VSR1 / VSR2  in  16 each  register-file read values.
REQ-013 Mem_bypass_val  in  16  memory-stage forwarded value.
REQ-014 aluout  out  16  registered ALU or LEA result.
REQ-015 pcout  out  16  registered computed address.
REQ-016 W_Control_out  out  2  registered W_Control_in.
REQ-017 Mem_Control_out  out  1  registered Mem_Control_in.
REQ-018 M_Data  out  16  registered store data.
REQ-019 dr  out  3  registered destination register.
REQ-020 IR_Exec  out  16  registered IR.
REQ-021 NZP  out  3  registered branch condition mask.
REQ-022 sr1 / sr2  out  3 each  combinational source-register indices.

Function
REQ-023 Opcodes: ADD 0001, AND 0101, NOT 1001, BR 0000, JMP 1100, LD 0010, LDR 0110, LDI 1010, LEA 1110, ST 0011, STR 0111, STI 1011.
REQ-024 val_1 = bypass_alu_1 ? aluout : bypass_mem_1 ? Mem_bypass_val : VSR1. ALU bypass wins when both are asserted. The same rule with *_2 and VSR2 gives val_2.
REQ-025 Operand 2 = op2select ? val_2 : sign-extended IR[4:0].
REQ-026 alu_control: 00 ADD (mod 2^16, carry discarded), 01 bitwise AND, 10 NOT val_1, 11 reserved (result 0).
REQ-027 Address base = pcselect2 ? npc_in : val_1. Offset by pcselect1: 00 sext IR[10:0], 01 sext IR[8:0], 10 sext IR[5:0], 11 zero. Address = base + offset, mod 2^16.
REQ-028 aluout captures the ALU result for ADD/AND/NOT and the address for LEA. For all other opcodes it holds its previous value.
REQ-029 pcout captures the address for every opcode.
REQ-030 M_Data captures val_2 for ST/STR/STI. For all other opcodes it holds its previous value.
REQ-031 dr captures IR[11:9] for ADD/AND/NOT/LD/LDR/LDI/LEA, and 0 otherwise.
REQ-032 NZP captures IR[11:9] for BR, 3'b111 for JMP, and 3'b000 otherwise.
REQ-033 IR_Exec, W_Control_out and Mem_Control_out capture their inputs.
REQ-034 Latency: exactly 1 cycle from input sampling edge to registered outputs.
REQ-035 When enable_execute=0, every registered output holds its value.
REQ-036 sr1 = IR[8:6] combinationally. sr2 = IR[11:9] for ST/STR/STI, and IR[2:0] otherwise. Neither depends on enable_execute.
REQ-037 The ALU bypass uses the currently registered aluout, i.e. a back-to-back forward.

Reset
REQ-038 On reset assertion, all registered outputs clear to 0 immediately, without waiting for a clock edge, including mid-operation.
REQ-039 While reset is high, no captures occur. The first capture is on the first rising edge with reset low and enable_execute=1.

Verification
REQ-040 Stimulus: IR=0x1642, VSR1=0x0005, VSR2=0x0003, E_control=6'b000001, enable=1. Response after one edge: aluout=0x0008, dr=3, IR_Exec=0x1642, NZP=0.
REQ-041 Stimulus: IR=0x127F, VSR1=0x0000, op2select=0. Response: aluout=0xFFFF (wrap).
REQ-042 Stimulus: aluout=0x0008 with bypass_alu_1=bypass_mem_1=1, Mem_bypass_val=0x1234, IR=0x1642, VSR2=0x0003. Response: aluout=0x000B.
REQ-043 Stimulus: IR=0x0404, npc_in=0x3001, E_control=6'b000110. Response: pcout=0x3005, NZP=3'b010, dr=0.
REQ-044 Stimulus: enable_execute=0 for 3 cycles with changing inputs. Response: all registered outputs unchanged, while sr1/sr2 track IR.
REQ-045 Stimulus: reset pulsed mid-cycle after REQ-040. Response: outputs go to 0 before the next edge.
